if_stage: RTL

//   Instruction-fetch stage of the 5-stage MIPS pipeline; feeds the decode stage.
//   - Holds the PC and drives the word address into instruction memory.
//   - Latches the returned instruction and PC+4 into the IF/ID pipeline register.
//   - Honours stall requests from the hazard unit and flush/redirect requests from branch resolution.
//   - Keeps fetch and bubble performance counters.

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr : word index driven by the fetch stage (ADDR_W bits)
//   imem_data : instruction word returned combinationally by the memory
// Modports:
//   master : fetch-stage side (drives imem_addr, receives imem_data)
//   slave  : memory side (receives imem_addr, drives imem_data)
interface if_stage_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;

    modport master (
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        output imem_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of a 5-stage MIPS pipeline.
// Holds the fetch PC, addresses instruction memory with the word index of the
// PC, latches the returned instruction and PC+4 into the IF/ID register, and
// counts fetched instructions and bubble cycles.
// Ports:
//   clk            clock, rising-edge active
//   rst            asynchronous active-high reset
//   stall          hold PC and IF/ID this cycle
//   branch_taken   redirect PC to branch_target and flush IF/ID (beats stall)
//   branch_target  byte address of the redirect target
//   imem           instruction-memory bus (master): imem_addr out, imem_data in
//   pc             current fetch PC (byte address)
//   if_id_inst     IF/ID instruction, 0 (NOP) when not valid
//   if_id_pc4      IF/ID PC+4 of the latched instruction
//   if_id_valid    IF/ID holds a real fetched instruction
//   fetch_cnt      saturating count of instructions latched into IF/ID
//   bubble_cnt     saturating count of stalled or flushed cycles
module if_stage #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    if_stage_if.master       imem,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [31:0]      pc_q,          pc_d;
    logic [31:0]      if_id_inst_q,  if_id_inst_d;
    logic [31:0]      if_id_pc4_q,   if_id_pc4_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0] fetch_cnt_q,   fetch_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q,  bubble_cnt_d;

    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] fetch_cnt_inc;
    logic [CNT_W-1:0] bubble_cnt_inc;

    // Only the word-index bits of the PC reach memory; upper bits are ignored,
    // so the memory index wraps naturally after the last word.
    assign imem.imem_addr = pc_q[ADDR_W+1:2];

    assign pc_plus4 = pc_q + 32'd4;

    // Saturating increments: hold at all-ones rather than wrap.
    assign fetch_cnt_inc  = (fetch_cnt_q  == '1) ? fetch_cnt_q  : fetch_cnt_q  + CNT_W'(1);
    assign bubble_cnt_inc = (bubble_cnt_q == '1) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);

    always_comb begin
        pc_d          = pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        fetch_cnt_d   = fetch_cnt_q;
        bubble_cnt_d  = bubble_cnt_q;

        if (branch_taken) begin
            // Redirect: word-align the target and squash the IF/ID entry.
            pc_d          = branch_target & ~32'h3;
            if_id_inst_d  = '0;
            if_id_pc4_d   = '0;
            if_id_valid_d = 1'b0;
            bubble_cnt_d  = bubble_cnt_inc;
        end else if (stall) begin
            bubble_cnt_d  = bubble_cnt_inc;
        end else begin
            if_id_inst_d  = imem.imem_data;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
            fetch_cnt_d   = fetch_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= '0;
            if_id_inst_q  <= '0;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
            fetch_cnt_q   <= '0;
            bubble_cnt_q  <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_cnt_q   <= fetch_cnt_d;
            bubble_cnt_q  <= bubble_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;
    assign fetch_cnt   = fetch_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule
